// File: rtl/visible_watermarking_if.sv
// APB-style register port plus the pixel output stream of the watermarking engine.
interface visible_watermarking_if #(
  parameter int Amba_Word       = 16,
  parameter int Amba_Addr_Depth = 20,
  parameter int Data_Depth      = 8
);
  logic                       PENABLE;
  logic                       PSEL;
  logic                       PWRITE;
  logic [Amba_Addr_Depth:0]   PADDR;
  logic [Amba_Word-1:0]       PWDATA;
  logic [Amba_Word-1:0]       PRDATA;
  logic                       Image_Done;
  logic [Data_Depth-1:0]      Pixel_Data;
  logic                       new_pixel;

  modport slave (
    input  PENABLE, PSEL, PWRITE, PADDR, PWDATA,
    output PRDATA, Image_Done, Pixel_Data, new_pixel
  );

  modport master (
    output PENABLE, PSEL, PWRITE, PADDR, PWDATA,
    input  PRDATA, Image_Done, Pixel_Data, new_pixel
  );
endinterface

// File: rtl/visible_watermarking.sv
// Block-based visible watermark blender: per block, M^2 stat cycles, 39 calc cycles, then one
// strobe every 2 cycles; zero-wait APB writes are always accepted, the pixel stream has no backpressure.
module visible_watermarking #(
  parameter int Amba_Word       = 16,
  parameter int Amba_Addr_Depth = 20,
  parameter int Data_Depth      = 8,
  parameter int Block_Depth     = 7,
  parameter int Max_Block_Size  = 5184,
  parameter int Max_Img_Size    = 12
) (
  input  logic clk,
  input  logic rst,
  visible_watermarking_if.slave bus
);
  localparam int AW       = Amba_Addr_Depth + 1;
  localparam int DW       = Data_Depth;
  localparam int STORE    = 10 + 2 * Max_Img_Size * Max_Img_Size;
  localparam int IDX_W    = $clog2(STORE);
  localparam int SUM_MIN  = 2 * DW + Block_Depth;
  localparam int SUM_NEED = $clog2(Max_Block_Size * ((1 << DW) - 1) + 1);
  localparam int SUM_W    = (SUM_MIN > SUM_NEED) ? SUM_MIN : SUM_NEED;
  localparam int PW       = 2 * DW;
  localparam int MIX_W    = 2 * DW + 1;
  localparam int A_LAST   = SUM_W - 1;
  localparam int B_LAST   = SUM_W + PW - 1;
  localparam int CNT_W    = $clog2(B_LAST + 1);

  typedef enum logic [2:0] {IDLE, STAT, CALC, EMIT, DONE} state_t;

  logic [DW-1:0] mem [STORE];

  logic wr_en, rd_en, start;
  assign wr_en = bus.PSEL & bus.PENABLE & bus.PWRITE;
  assign rd_en = bus.PSEL & bus.PENABLE & ~bus.PWRITE;
  assign start = wr_en && (bus.PADDR == '0) && bus.PWDATA[0];

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return (a < AW'(STORE)) ? mem[a[IDX_W-1:0]] : '0;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STORE; i++) mem[i] <= '0;
      bus.PRDATA <= '0;
    end else begin
      if (wr_en && (bus.PADDR < AW'(STORE))) mem[bus.PADDR[IDX_W-1:0]] <= bus.PWDATA[DW-1:0];
      if (rd_en) bus.PRDATA <= Amba_Word'(rd(bus.PADDR));
    end
  end

  state_t         state;
  logic           ph;
  logic [DW-1:0]  np_q, m_q, iw_q, bthr_q, amin_q, amax_q, bmin_q, bmax_q;
  logic [PW-1:0]  m_sq;
  logic [DW:0]    br, bc;
  logic [DW-1:0]  r, c;
  logic [SUM_W-1:0] sum;
  logic [DW-1:0]  mn, mx, alpha, beta;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] a_dq;
  logic [PW-1:0]  a_rem, b_dq, c_dq;
  logic [DW-1:0]  b_rem, c_rem;

  // Address of the co-located primary / watermark pixel for the current (block, r, c).
  logic [AW-1:0] row_a, p_addr, w_addr;
  logic [DW-1:0] pix_p, pix_w;
  assign row_a  = AW'(br) + AW'(r);
  assign p_addr = AW'(10) + row_a * AW'(np_q) + AW'(bc) + AW'(c);
  assign w_addr = p_addr + AW'(np_q) * AW'(np_q);
  assign pix_p  = rd(p_addr);
  assign pix_w  = rd(w_addr);

  logic last_c, last_r, last_bc, last_br;
  assign last_c  = (c == m_q - DW'(1));
  assign last_r  = (r == m_q - DW'(1));
  assign last_bc = ((DW+2)'(bc) + (DW+2)'(m_q)) >= (DW+2)'(np_q);
  assign last_br = ((DW+2)'(br) + (DW+2)'(m_q)) >= (DW+2)'(np_q);

  logic [SUM_W-1:0] sum_n;
  logic [DW-1:0]    mn_n, mx_n;
  assign sum_n = sum + SUM_W'(pix_p);
  assign mn_n  = (pix_p < mn) ? pix_p : mn;
  assign mx_n  = (pix_p > mx) ? pix_p : mx;

  // Restoring dividers: A gives mu = sum / M^2, then B and C run in parallel over Iwhite.
  logic [PW:0]      a_sh, a_sub;
  logic             a_ge;
  logic [PW-1:0]    a_rem_n;
  logic [SUM_W-1:0] a_dq_n;
  logic [DW-1:0]    mu_n;
  assign a_sh    = {a_rem, a_dq[SUM_W-1]};
  assign a_ge    = a_sh >= {1'b0, m_sq};
  assign a_sub   = a_sh - {1'b0, m_sq};
  assign a_rem_n = a_ge ? a_sub[PW-1:0] : a_sh[PW-1:0];
  assign a_dq_n  = {a_dq[SUM_W-2:0], a_ge};
  assign mu_n    = a_dq_n[DW-1:0];

  logic [DW:0]   b_sh, b_sub, c_sh, c_sub;
  logic          b_ge, c_ge;
  logic [DW-1:0] b_rem_n, c_rem_n;
  logic [PW-1:0] b_dq_n, c_dq_n, b_load, c_load;
  logic [DW-1:0] a_span, b_span, iw_mu;
  assign b_sh    = {b_rem, b_dq[PW-1]};
  assign b_ge    = b_sh >= {1'b0, iw_q};
  assign b_sub   = b_sh - {1'b0, iw_q};
  assign b_rem_n = b_ge ? b_sub[DW-1:0] : b_sh[DW-1:0];
  assign b_dq_n  = {b_dq[PW-2:0], b_ge};
  assign c_sh    = {c_rem, c_dq[PW-1]};
  assign c_ge    = c_sh >= {1'b0, iw_q};
  assign c_sub   = c_sh - {1'b0, iw_q};
  assign c_rem_n = c_ge ? c_sub[DW-1:0] : c_sh[DW-1:0];
  assign c_dq_n  = {c_dq[PW-2:0], c_ge};
  assign a_span  = amax_q - amin_q;
  assign b_span  = bmax_q - bmin_q;
  assign iw_mu   = iw_q - mu_n;
  assign b_load  = PW'(a_span) * PW'(mu_n);
  assign c_load  = PW'(b_span) * PW'(iw_mu);

  logic          tex;
  logic [MIX_W-1:0] mix, q100;
  logic [DW-1:0] pix_out;
  assign tex     = (mx - mn) > bthr_q;
  assign mix     = MIX_W'(alpha) * MIX_W'(pix_p) + MIX_W'(beta) * MIX_W'(pix_w);
  assign q100    = mix / MIX_W'(100);
  assign pix_out = (q100 > MIX_W'(iw_q)) ? iw_q : q100[DW-1:0];

  logic unused_ok;
  assign unused_ok = ^{bus.PWDATA[Amba_Word-1:DW], a_sub[PW], b_sub[DW], c_sub[DW]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;  ph <= 1'b0;  cnt <= '0;
      np_q <= '0;  m_q <= '0;  iw_q <= '0;  bthr_q <= '0;
      amin_q <= '0;  amax_q <= '0;  bmin_q <= '0;  bmax_q <= '0;  m_sq <= '0;
      br <= '0;  bc <= '0;  r <= '0;  c <= '0;
      sum <= '0;  mn <= '0;  mx <= '0;  alpha <= '0;  beta <= '0;
      a_dq <= '0;  a_rem <= '0;  b_dq <= '0;  b_rem <= '0;  c_dq <= '0;  c_rem <= '0;
      bus.Image_Done <= 1'b0;  bus.Pixel_Data <= '0;  bus.new_pixel <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (state == DONE) bus.Image_Done <= 1'b1;
          if (start) begin
            iw_q <= mem[1];  np_q <= mem[2];  m_q <= mem[4];  bthr_q <= mem[5];
            amin_q <= mem[6];  amax_q <= mem[7];  bmin_q <= mem[8];  bmax_q <= mem[9];
            m_sq <= PW'(mem[4]) * PW'(mem[4]);
            br <= '0;  bc <= '0;  r <= '0;  c <= '0;  ph <= 1'b0;
            sum <= '0;  mn <= '1;  mx <= '0;
            bus.Image_Done <= 1'b0;
            state <= (mem[4] == '0) ? DONE : STAT;
          end
        end
        STAT: begin
          sum <= sum_n;  mn <= mn_n;  mx <= mx_n;
          if (!last_c) c <= c + DW'(1);
          else begin
            c <= '0;
            if (!last_r) r <= r + DW'(1);
            else begin
              r <= '0;  a_dq <= sum_n;  a_rem <= '0;  cnt <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt <= CNT_W'(A_LAST)) begin
            a_dq <= a_dq_n;  a_rem <= a_rem_n;
            if (cnt == CNT_W'(A_LAST)) begin
              b_dq <= b_load;  b_rem <= '0;  c_dq <= c_load;  c_rem <= '0;
            end
          end else begin
            b_dq <= b_dq_n;  b_rem <= b_rem_n;  c_dq <= c_dq_n;  c_rem <= c_rem_n;
            if (cnt == CNT_W'(B_LAST)) begin
              alpha <= tex ? amax_q : amin_q + b_dq_n[DW-1:0];
              beta  <= tex ? bmin_q : bmin_q + c_dq_n[DW-1:0];
              ph    <= 1'b0;
              state <= EMIT;
            end
          end
        end
        EMIT: begin
          if (!ph) begin
            bus.Pixel_Data <= pix_out;  bus.new_pixel <= 1'b1;  ph <= 1'b1;
          end else begin
            bus.new_pixel <= 1'b0;  ph <= 1'b0;
            if (!last_c) c <= c + DW'(1);
            else begin
              c <= '0;
              if (!last_r) r <= r + DW'(1);
              else begin
                r <= '0;  sum <= '0;  mn <= '1;  mx <= '0;
                if (!last_bc) begin
                  bc <= bc + (DW+1)'(m_q);  state <= STAT;
                end else begin
                  bc <= '0;
                  if (!last_br) begin
                    br <= br + (DW+1)'(m_q);  state <= STAT;
                  end else state <= DONE;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_visible_watermarking.sv
// Directed bench for visible_watermarking with an image-level reference model feeding a pixel scoreboard.
module tb_visible_watermarking;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  visible_watermarking_if bus ();
  visible_watermarking dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int cap[$];
  int prim[144];
  int wm[144];
  int p_iw, p_np, p_m, p_bthr, p_amin, p_amax, p_bmin, p_bmax;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0;
  endtask

  task automatic apb_write(input int addr, input int data);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1;
    bus.PADDR = 21'(addr); bus.PWDATA = 16'(data);
    @(negedge clk);
  endtask

  task automatic apb_read(input int addr, output logic [31:0] data);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0;
    bus.PADDR = 21'(addr);
    @(negedge clk);
    data = 32'(bus.PRDATA);
    bus_idle();
  endtask

  task automatic load_image();
    int pv[9];
    pv = '{p_iw, p_np, p_np, p_m, p_bthr, p_amin, p_amax, p_bmin, p_bmax};
    for (int i = 0; i < 9; i++) apb_write(i + 1, pv[i]);
    for (int i = 0; i < 144; i++) apb_write(10 + i, prim[i]);
    for (int i = 0; i < 144; i++) apb_write(154 + i, wm[i]);
    bus_idle();
  endtask

  // Reference model: expected output pixels in block-raster order.
  task automatic build_expected();
    int nb, r0, c0, sum, mn, mx, mu, alpha, beta, p, w, o, idx;
    nb = p_np / p_m;
    for (int bk = 0; bk < nb * nb; bk++) begin
      r0 = (bk / nb) * p_m; c0 = (bk % nb) * p_m;
      sum = 0; mn = 255; mx = 0;
      for (int r = 0; r < p_m; r++)
        for (int c = 0; c < p_m; c++) begin
          p = prim[(r0 + r) * p_np + c0 + c];
          sum += p;
          if (p < mn) mn = p;
          if (p > mx) mx = p;
        end
      mu = sum / (p_m * p_m);
      if (mx - mn > p_bthr) begin
        alpha = p_amax; beta = p_bmin;
      end else begin
        alpha = p_amin + ((p_amax - p_amin) * mu) / p_iw;
        beta  = p_bmin + ((p_bmax - p_bmin) * (p_iw - mu)) / p_iw;
      end
      for (int r = 0; r < p_m; r++)
        for (int c = 0; c < p_m; c++) begin
          idx = (r0 + r) * p_np + c0 + c;
          o = (alpha * prim[idx] + beta * wm[idx]) / 100;
          if (o > p_iw) o = p_iw;
          exp_q.push_back(o);
        end
    end
  endtask

  task automatic start_run();
    build_expected();
    apb_write(0, 1);
    bus_idle();
  endtask

  task automatic run(input string tag, input int n);
    int cyc = 0;
    int seen = 0;
    logic [31:0] v;
    int e;
    cap.delete();
    while (seen < n && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (bus.new_pixel) begin
        v = 32'(bus.Pixel_Data);
        cap.push_back(int'(v));
        seen++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check(tag, v, 32'(e));
        end
      end
    end
    check({tag, "_count"}, 32'(seen), 32'(n));
  endtask

  task automatic check_done(input string tag);
    int pulses = 0;
    @(negedge clk);
    check({tag, "_done_low"}, 32'(bus.Image_Done), 0);
    check({tag, "_np_low"}, 32'(bus.new_pixel), 0);
    @(negedge clk);
    check({tag, "_done_set"}, 32'(bus.Image_Done), 1);
    repeat (30) begin
      @(negedge clk);
      if (bus.new_pixel) pulses++;
    end
    check({tag, "_no_extra"}, 32'(pulses), 0);
    check({tag, "_done_hold"}, 32'(bus.Image_Done), 1);
  endtask

  initial begin
    logic [31:0] rv;
    int regs[9];
    bus_idle();
    repeat (3) @(negedge clk);
    check("rst_done", 32'(bus.Image_Done), 0);
    check("rst_np", 32'(bus.new_pixel), 0);
    check("rst_pix", 32'(bus.Pixel_Data), 0);
    check("rst_prdata", 32'(bus.PRDATA), 0);
    rst = 1'b1;
    @(negedge clk);

    // Register load and readback
    regs = '{255, 12, 12, 3, 20, 83, 96, 25, 31};
    for (int i = 0; i < 9; i++) apb_write(i + 1, regs[i]);
    bus_idle();
    for (int i = 0; i < 9; i++) begin
      apb_read(i + 1, rv);
      check($sformatf("readback_%0d", i + 1), rv, 32'(regs[i]));
    end
    check("idle_done", 32'(bus.Image_Done), 0);
    check("idle_np", 32'(bus.new_pixel), 0);

    // Flat image: alpha=88, beta=28 everywhere
    p_iw = 255; p_np = 12; p_m = 3; p_bthr = 20;
    p_amin = 83; p_amax = 96; p_bmin = 25; p_bmax = 31;
    for (int i = 0; i < 144; i++) begin prim[i] = 100; wm[i] = 200; end
    load_image();
    start_run();
    run("flat", 144);
    check("flat_first", 32'(cap[0]), 144);
    check("flat_last", 32'(cap[143]), 144);
    check_done("flat");

    // Textured block 0, saturating block 1, random elsewhere
    for (int i = 0; i < 144; i++) begin
      prim[i] = $urandom_range(0, 255); wm[i] = $urandom_range(0, 255);
    end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        prim[r * 12 + c] = ((r + c) % 2 != 0) ? 100 : 0;
        wm[r * 12 + c] = 0;
        prim[r * 12 + c + 3] = ((r + c + 3) % 2 != 0) ? 255 : 0;
        wm[r * 12 + c + 3] = 255;
      end
    load_image();
    start_run();
    check("start_clears_done", 32'(bus.Image_Done), 0);
    run("tex", 144);
    check("tex_p0", 32'(cap[0]), 0);
    check("tex_p100", 32'(cap[1]), 96);
    check("sat_255", 32'(cap[9]), 255);
    check_done("tex");

    // Ordering: output equals primary pixel index
    p_amin = 100; p_amax = 100; p_bmin = 0; p_bmax = 0;
    for (int i = 0; i < 144; i++) begin prim[i] = i; wm[i] = $urandom_range(0, 255); end
    load_image();
    start_run();
    run("order", 144);
    check("order_9th", 32'(cap[8]), 26);
    check("order_10th", 32'(cap[9]), 3);
    check_done("order");

    // Reset in the middle of EMIT, then reprocess from block 0
    load_image();
    start_run();
    run("pre_rst", 5);
    check("pre_rst_5th", 32'(cap[4]), 13);
    rst = 1'b0;
    #1;
    check("mid_rst_np", 32'(bus.new_pixel), 0);
    check("mid_rst_pix", 32'(bus.Pixel_Data), 0);
    check("mid_rst_done", 32'(bus.Image_Done), 0);
    check("mid_rst_prdata", 32'(bus.PRDATA), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    load_image();
    start_run();
    run("rerun", 144);
    check("rerun_first", 32'(cap[0]), 0);
    check("rerun_4th", 32'(cap[3]), 12);
    check("rerun_10th", 32'(cap[9]), 3);
    check_done("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
